// File: rtl/sar_capdac_ctrl.sv
// SAR capacitor-DAC controller.
// Sequences a binary-search conversion on a split capacitor array: samples the
// top plate for SAMPLE_CYCLES clocks, then resolves one bit per clock from MSB
// to LSB using the comparator decision, and publishes the final code.
// The diff-cap bank is always driven with the complement of the main bank.
// Optional feature macro: SAR_CAPDAC_CAL_EN -- when defined, an idle controller
// drives cal_code onto the main bank while cal_mode is high.
module sar_capdac_ctrl #(
    parameter int NBITS         = 16,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_out,
    input  logic             cal_mode,
    input  logic [NBITS-1:0] cal_code,
    output logic [NBITS-1:0] cap_botplate_m,
    output logic [NBITS-1:0] cap_botplate_d,
    output logic             sample,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid
);

    // Sample counter runs 0..SAMPLE_CYCLES-1; keep at least one bit.
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    // Trial-bit index runs NBITS-1..0.
    localparam int KW = $clog2(NBITS);

    localparam logic [CW-1:0]    CNT_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [KW-1:0]    K_TOP    = KW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    sample_cnt;
    logic [KW-1:0]    bit_idx;
    logic [NBITS-1:0] trial_next;
    logic [NBITS-1:0] idle_code;

`ifdef SAR_CAPDAC_CAL_EN
    // Idle bank drive follows the calibration request.
    assign idle_code = cal_mode ? cal_code : '0;
`else
    // Calibration disabled: ports exist but the idle bank stays discharged.
    assign idle_code = '0;
    logic unused_cal;
    assign unused_cal = ^{cal_mode, cal_code};
`endif

    // The diff bank mirrors the main bank at all times, including reset.
    assign cap_botplate_d = ~cap_botplate_m;

    // Next main-bank code for one binary-search step: resolve the current
    // trial bit from the comparator and raise the next lower trial bit.
    always_comb begin
        trial_next          = cap_botplate_m;
        trial_next[bit_idx] = comp_out;
        if (bit_idx != '0) begin
            trial_next[bit_idx - 1'b1] = 1'b1;
        end
    end

    // Conversion sequencer with registered bank drive and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cap_botplate_m <= '0;
            sample         <= 1'b0;
            busy           <= 1'b0;
            result         <= '0;
            result_valid   <= 1'b0;
            sample_cnt     <= '0;
            bit_idx        <= K_TOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        // start wins over a concurrent calibration request
                        state          <= ST_SAMPLE;
                        sample         <= 1'b1;
                        busy           <= 1'b1;
                        cap_botplate_m <= '0;
                        sample_cnt     <= '0;
                    end else begin
                        cap_botplate_m <= idle_code;
                    end
                end

                ST_SAMPLE: begin
                    if (sample_cnt == CNT_LAST) begin
                        state          <= ST_CONVERT;
                        sample         <= 1'b0;
                        cap_botplate_m <= MSB_ONLY;
                        bit_idx        <= K_TOP;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end

                ST_CONVERT: begin
                    cap_botplate_m <= trial_next;
                    if (bit_idx == '0) begin
                        state        <= ST_DONE;
                        result       <= trial_next;
                        result_valid <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end

                ST_DONE: begin
                    // calibration requests are not honoured on this edge
                    state          <= ST_IDLE;
                    result_valid   <= 1'b0;
                    busy           <= 1'b0;
                    cap_botplate_m <= '0;
                end

                default: begin
                    state          <= ST_IDLE;
                    sample         <= 1'b0;
                    busy           <= 1'b0;
                    result_valid   <= 1'b0;
                    cap_botplate_m <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_capdac_ctrl.sv
// Testbench for sar_capdac_ctrl: randomized conversions on a 16-bit array
// checked cycle by cycle against a binary-search reference model, plus
// directed 4-bit trace, reset-abort, calibration and sample-length scenarios.
module tb_sar_capdac_ctrl;

    localparam int N16  = 16;
    localparam int SC16 = 2;

    int checks = 0;
    int errors = 0;

    logic clk;
    logic rst;

    // 16-bit main instance
    logic        start16, comp16, cal_mode;
    logic [15:0] cal_code;
    logic [15:0] m16, d16, result16;
    logic        sample16, busy16, rv16;
    logic [15:0] last_result16;

    // 4-bit directed instance
    logic       start4, comp4;
    logic [3:0] m4, d4, result4;
    logic       sample4, busy4, rv4;

    // sample-length instances (NBITS=6, SAMPLE_CYCLES=1 and 5)
    logic       start_s, comp_s;
    logic [5:0] ms1, ds1, res_s1, ms5, ds5, res_s5;
    logic       sample_s1, busy_s1, rv_s1, sample_s5, busy_s5, rv_s5;

    sar_capdac_ctrl #(.NBITS(N16), .SAMPLE_CYCLES(SC16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .comp_out(comp16),
        .cal_mode(cal_mode), .cal_code(cal_code),
        .cap_botplate_m(m16), .cap_botplate_d(d16), .sample(sample16),
        .busy(busy16), .result(result16), .result_valid(rv16)
    );

    sar_capdac_ctrl #(.NBITS(4), .SAMPLE_CYCLES(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .comp_out(comp4),
        .cal_mode(1'b0), .cal_code(4'h0),
        .cap_botplate_m(m4), .cap_botplate_d(d4), .sample(sample4),
        .busy(busy4), .result(result4), .result_valid(rv4)
    );

    sar_capdac_ctrl #(.NBITS(6), .SAMPLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s), .comp_out(comp_s),
        .cal_mode(1'b0), .cal_code(6'h00),
        .cap_botplate_m(ms1), .cap_botplate_d(ds1), .sample(sample_s1),
        .busy(busy_s1), .result(res_s1), .result_valid(rv_s1)
    );

    sar_capdac_ctrl #(.NBITS(6), .SAMPLE_CYCLES(5)) u_s5 (
        .clk(clk), .rst(rst), .start(start_s), .comp_out(comp_s),
        .cal_mode(1'b0), .cal_code(6'h00),
        .cap_botplate_m(ms5), .cap_botplate_d(ds5), .sample(sample_s5),
        .busy(busy_s5), .result(res_s5), .result_valid(rv_s5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion on u16, checked every cycle. The model: during
    // trial step i the bank shows the already-decided upper bits of the target
    // code plus a single 1 at bit N-1-i; the final code is the comparator
    // decisions read MSB first. noisy re-asserts start while busy.
    task automatic run_conv16(input logic [15:0] bits, input bit noisy);
        logic [15:0] exp_m;
        logic [15:0] hi_mask;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        for (int i = 0; i < SC16; i++) begin
            checks++;
            if ({sample16, busy16, rv16, m16, d16} !== {1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF}) begin
                errors++;
                $display("FAIL sample_phase[%0d]: got s=%b b=%b v=%b m=%h d=%h expected s=1 b=1 v=0 m=0000 d=ffff",
                         i, sample16, busy16, rv16, m16, d16);
            end
            checks++;
            if (result16 !== last_result16) begin
                errors++;
                $display("FAIL result_hold_sample: got %h expected %h", result16, last_result16);
            end
            if (noisy) start16 = 1'($urandom_range(0, 1));
            comp16 = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < N16; i++) begin
            hi_mask = ~(16'hFFFF >> i);
            exp_m   = (bits & hi_mask) | (16'h8000 >> i);
            checks++;
            if ({sample16, busy16, rv16, m16, d16} !== {1'b0, 1'b1, 1'b0, exp_m, ~exp_m}) begin
                errors++;
                $display("FAIL convert_step[%0d]: got s=%b b=%b v=%b m=%h d=%h expected s=0 b=1 v=0 m=%h d=%h",
                         i, sample16, busy16, rv16, m16, d16, exp_m, ~exp_m);
            end
            comp16 = bits[15 - i];
            if (noisy) start16 = 1'($urandom_range(0, 1));
            step();
        end
        checks++;
        if ({sample16, busy16, rv16, m16, d16, result16} !== {1'b0, 1'b1, 1'b1, bits, ~bits, bits}) begin
            errors++;
            $display("FAIL done_cycle: got s=%b b=%b v=%b m=%h d=%h r=%h expected s=0 b=1 v=1 m=%h d=%h r=%h",
                     sample16, busy16, rv16, m16, d16, result16, bits, ~bits, bits);
        end
        start16 = noisy;
        comp16  = 1'($urandom_range(0, 1));
        step();
        checks++;
        if ({sample16, busy16, rv16, m16, d16, result16} !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, bits}) begin
            errors++;
            $display("FAIL idle_after_done: got s=%b b=%b v=%b m=%h d=%h r=%h expected s=0 b=0 v=0 m=0000 d=ffff r=%h",
                     sample16, busy16, rv16, m16, d16, result16, bits);
        end
        start16 = 1'b0;
        last_result16 = bits;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({m16, d16, sample16, busy16, result16, rv16} !== {16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_u16: got m=%h d=%h s=%b b=%b r=%h v=%b expected 0000 ffff 0 0 0000 0",
                     m16, d16, sample16, busy16, result16, rv16);
        end
        checks++;
        if ({m4, d4, sample4, busy4, result4, rv4} !== {4'h0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_u4: got m=%h d=%h s=%b b=%b r=%h v=%b expected 0 f 0 0 0 0",
                     m4, d4, sample4, busy4, result4, rv4);
        end
        step();
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({m16, busy16, sample16, rv16} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_no_start: got m=%h b=%b s=%b v=%b expected 0000 0 0 0",
                     m16, busy16, sample16, rv16);
        end
        last_result16 = 16'h0000;
    endtask

    task automatic test_nbits4();
        bit         pat[4];
        logic [3:0] exp_tr[4];
        logic [3:0] trace[$];
        int         edges;
        int         ci;
        bit         d_ok;
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_tr = '{4'b1000, 4'b1100, 4'b1010, 4'b1011};
        edges  = 0;
        ci     = 0;
        d_ok   = 1'b1;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        while (!rv4 && edges < 20) begin
            if (d4 !== ~m4) d_ok = 1'b0;
            if (busy4 && !sample4 && ci < 4) begin
                trace.push_back(m4);
                comp4 = pat[ci];
                ci++;
            end
            step();
            edges++;
        end
        checks++;
        if (edges != 6) begin
            errors++;
            $display("FAIL n4_latency: got %0d edges expected 6", edges);
        end
        checks++;
        if (trace.size() != 4) begin
            errors++;
            $display("FAIL n4_trace_len: got %0d expected 4", trace.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (trace[i] !== exp_tr[i]) begin
                    errors++;
                    $display("FAIL n4_trace[%0d]: got %b expected %b", i, trace[i], exp_tr[i]);
                end
            end
        end
        checks++;
        if ({result4, m4, d_ok} !== {4'b1011, 4'b1011, 1'b1}) begin
            errors++;
            $display("FAIL n4_result: got r=%b m=%b d_ok=%b expected 1011 1011 1", result4, m4, d_ok);
        end
        step();
        checks++;
        if ({rv4, busy4, m4} !== {1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL n4_idle: got v=%b b=%b m=%b expected 0 0 0000", rv4, busy4, m4);
        end
    endtask

    task automatic test_comp_const();
        run_conv16(16'h0000, 1'b0);
        run_conv16(16'hFFFF, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_conv16(16'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_back_to_back();
        run_conv16(16'($urandom), 1'b1);
        run_conv16(16'($urandom), 1'b1);
        run_conv16(16'h5A3C, 1'b0);
    endtask

    task automatic test_abort();
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        repeat (SC16) step();
        // 13 resolved bits brings the search to trial bit 2
        repeat (13) begin
            comp16 = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy16, sample16, rv16, m16, d16, result16} !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000}) begin
            errors++;
            $display("FAIL abort_async: got b=%b s=%b v=%b m=%h d=%h r=%h expected 0 0 0 0000 ffff 0000",
                     busy16, sample16, rv16, m16, d16, result16);
        end
        step();
        rst = 1'b0;
        last_result16 = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({rv16, busy16} !== 2'b00) begin
                errors++;
                $display("FAIL abort_no_pulse[%0d]: got v=%b b=%b expected 0 0", i, rv16, busy16);
            end
            step();
        end
        run_conv16(16'($urandom), 1'b0);
    endtask

    task automatic test_cal();
        logic [15:0] exp_cal;
        logic [15:0] code;
        for (int n = 0; n < 2; n++) begin
            code     = (n == 0) ? 16'hA5A5 : 16'($urandom);
            cal_mode = 1'b1;
            cal_code = code;
            start16  = 1'b0;
`ifdef SAR_CAPDAC_CAL_EN
            exp_cal = code;
`else
            exp_cal = 16'h0000;
`endif
            step();
            checks++;
            if ({m16, d16, busy16} !== {exp_cal, ~exp_cal, 1'b0}) begin
                errors++;
                $display("FAIL cal_drive[%0d]: got m=%h d=%h b=%b expected m=%h d=%h b=0",
                         n, m16, d16, busy16, exp_cal, ~exp_cal);
            end
        end
        // start takes priority over cal_mode; cal_mode is ignored while busy
        run_conv16(16'($urandom), 1'b0);
        cal_mode = 1'b0;
        step();
        checks++;
        if ({m16, d16} !== {16'h0000, 16'hFFFF}) begin
            errors++;
            $display("FAIL cal_release: got m=%h d=%h expected 0000 ffff", m16, d16);
        end
    endtask

    task automatic test_sample_len();
        int  s1_cnt, s5_cnt, b1_cnt, b5_cnt, v1_cnt, v5_cnt;
        bit  d_ok;
        s1_cnt = 0; s5_cnt = 0; b1_cnt = 0; b5_cnt = 0; v1_cnt = 0; v5_cnt = 0;
        d_ok    = 1'b1;
        comp_s  = 1'b1;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        for (int i = 0; i < 25; i++) begin
            s1_cnt += int'(sample_s1);
            s5_cnt += int'(sample_s5);
            b1_cnt += int'(busy_s1);
            b5_cnt += int'(busy_s5);
            v1_cnt += int'(rv_s1);
            v5_cnt += int'(rv_s5);
            if (ds1 !== ~ms1 || ds5 !== ~ms5) d_ok = 1'b0;
            step();
        end
        checks++;
        if (s1_cnt != 1) begin
            errors++;
            $display("FAIL sample_len_1: got %0d cycles expected 1", s1_cnt);
        end
        checks++;
        if (s5_cnt != 5) begin
            errors++;
            $display("FAIL sample_len_5: got %0d cycles expected 5", s5_cnt);
        end
        checks++;
        if (b1_cnt != 8 || b5_cnt != 12) begin
            errors++;
            $display("FAIL busy_len: got %0d/%0d cycles expected 8/12", b1_cnt, b5_cnt);
        end
        checks++;
        if (v1_cnt != 1 || v5_cnt != 1) begin
            errors++;
            $display("FAIL valid_pulses: got %0d/%0d expected 1/1", v1_cnt, v5_cnt);
        end
        checks++;
        if ({res_s1, res_s5, d_ok} !== {6'h3F, 6'h3F, 1'b1}) begin
            errors++;
            $display("FAIL s_results: got %h/%h d_ok=%b expected 3f/3f 1", res_s1, res_s5, d_ok);
        end
    endtask

    initial begin
        rst = 1'b1;
        start16 = 1'b0; comp16 = 1'b0; cal_mode = 1'b0; cal_code = 16'h0000;
        start4 = 1'b0; comp4 = 1'b0;
        start_s = 1'b0; comp_s = 1'b0;
        last_result16 = 16'h0000;

        test_reset();
        test_nbits4();
        test_comp_const();
        test_random();
        test_back_to_back();
        test_abort();
        test_cal();
        test_sample_len();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
